// File: rtl/vga_pkg.sv
// vga_pkg -- shared timing constants and types for the VGA raster slice.
//
// Holds the 640x480@60 Hz timing numbers (sync-first counter convention),
// the snake grid geometry and the raster-position struct used by the
// pixel pipeline. Optional cell-coordinate logic is enabled elsewhere by
// the VGA_CELL_COORD_EN macro.
package vga_pkg;

  // Horizontal timing in pixel clocks.
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_VIS_START = 144;
  localparam int VGA_H_VIS_END   = 784;

  // Vertical timing in lines.
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_VIS_START = 35;
  localparam int VGA_V_VIS_END   = 515;

  // System clocks per pixel (100 MHz -> 25 MHz).
  localparam int VGA_CLK_DIV     = 4;

  // Grid geometry: 640/10 x 480/10 cells.
  localparam int VGA_CELL_PX     = 10;
  localparam int VGA_GRID_W      = 64;
  localparam int VGA_GRID_H      = 48;

  localparam int COUNT_W         = 10;
  localparam int CELL_W          = 7;

  typedef struct packed {
    logic [COUNT_W-1:0] hCount;
    logic [COUNT_W-1:0] vCount;
    logic               bright;
  } raster_pos_t;

  // Number of bits needed to hold 0..n-1 (at least one bit).
  function automatic int counterWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter -- one raster axis (horizontal or vertical).
//
// Counts 0..TOTAL-1 on each advance strobe and wraps to 0. The sync and
// visible decodes are registered from the next count value, so they change
// on the same edge as the count and always describe the value on `count`.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   advance  in   step the counter this clock
//   count    out  current position, 0..TOTAL-1
//   sync     out  active-low sync (low for count 0..SYNC-1)
//   visible  out  high for VIS_START <= count < VIS_END
//   wrap     out  combinational: the count wraps to 0 on the coming edge
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL     = VGA_H_TOTAL,
  parameter int SYNC      = VGA_H_SYNC,
  parameter int VIS_START = VGA_H_VIS_START,
  parameter int VIS_END   = VGA_H_VIS_END
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               advance,
  output logic [COUNT_W-1:0] count,
  output logic               sync,
  output logic               visible,
  output logic               wrap
);

  localparam logic [COUNT_W-1:0] LAST    = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] SYNC_W  = COUNT_W'(SYNC);
  localparam logic [COUNT_W-1:0] VIS_LO  = COUNT_W'(VIS_START);
  localparam logic [COUNT_W-1:0] VIS_HI  = COUNT_W'(VIS_END);

  logic [COUNT_W-1:0] countReg;
  logic [COUNT_W-1:0] countNext;
  logic               syncReg;
  logic               visibleReg;

  assign wrap = advance && (countReg == LAST);

  always_comb begin
    countNext = countReg;
    if (advance) begin
      countNext = wrap ? '0 : countReg + COUNT_W'(1);
    end
  end

  // Decodes are taken from countNext so they land on the same edge as the
  // count itself (no one-pixel skew).
  always_ff @(posedge clk) begin
    if (reset) begin
      countReg   <= '0;
      syncReg    <= 1'b0;
      visibleReg <= 1'b0;
    end else begin
      countReg   <= countNext;
      syncReg    <= (countNext >= SYNC_W);
      visibleReg <= (countNext >= VIS_LO) && (countNext < VIS_HI);
    end
  end

  assign count   = countReg;
  assign sync    = syncReg;
  assign visible = visibleReg;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- 640x480@60 Hz VGA raster timing from the system clock.
//
// A prescaler produces a one-clock pix_en strobe every CLK_DIV clocks; the
// horizontal and vertical axis counters advance on it. hSync/vSync/bright
// and the cell coordinates are registered alongside the counters so they
// always match the hCount/vCount currently presented.
//
// Optional feature: define VGA_CELL_COORD_EN to build the divider-free
// grid-cell counters (cellX/cellY). Without it cellX/cellY are tied to 0.
//
// Ports:
//   clk         in   system clock (100 MHz)
//   reset       in   synchronous, active-high
//   pix_en      out  one-clock strobe every CLK_DIV clocks
//   hCount      out  horizontal count, 0..H_TOTAL-1
//   vCount      out  vertical count, 0..V_TOTAL-1
//   hSync       out  active-low horizontal sync
//   vSync       out  active-low vertical sync
//   bright      out  high inside the visible window
//   line_tick   out  one-clock pulse when hCount becomes 0
//   frame_tick  out  one-clock pulse when (hCount,vCount) becomes (0,0)
//   cellX       out  visible column / CELL_PX
//   cellY       out  visible row / CELL_PX
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV     = VGA_CLK_DIV,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_VIS_START = VGA_H_VIS_START,
  parameter int H_VIS_END   = VGA_H_VIS_END,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_VIS_START = VGA_V_VIS_START,
  parameter int V_VIS_END   = VGA_V_VIS_END,
  parameter int CELL_PX     = VGA_CELL_PX
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pix_en,
  output logic [COUNT_W-1:0] hCount,
  output logic [COUNT_W-1:0] vCount,
  output logic               hSync,
  output logic               vSync,
  output logic               bright,
  output logic               line_tick,
  output logic               frame_tick,
  output logic [CELL_W-1:0]  cellX,
  output logic [CELL_W-1:0]  cellY
);

  localparam int PRE_W = counterWidth(CLK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  // Parameter sanity, checked in simulation only.
  always @(posedge clk) begin
    assert (CLK_DIV >= 1 && H_VIS_END <= H_TOTAL && V_VIS_END <= V_TOTAL);
  end

  // ---------------------------------------------------------------------
  // Prescaler. pix_en is registered so it is 0 in reset and first rises
  // CLK_DIV clocks after reset is released; with CLK_DIV=1 it then stays
  // high every clock.
  // ---------------------------------------------------------------------
  logic [PRE_W-1:0] prescalerReg;
  logic             pixEnReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      prescalerReg <= '0;
      pixEnReg     <= 1'b0;
    end else begin
      pixEnReg     <= (prescalerReg == PRE_LAST);
      prescalerReg <= (prescalerReg == PRE_LAST) ? '0 : prescalerReg + PRE_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Axis counters. The vertical axis steps once per horizontal wrap.
  // ---------------------------------------------------------------------
  logic [COUNT_W-1:0] hCountInt;
  logic [COUNT_W-1:0] vCountInt;
  logic               hSyncInt;
  logic               vSyncInt;
  logic               hVisible;
  logic               vVisible;
  logic               hWrap;
  logic               vWrap;

  vga_axis_counter #(
    .TOTAL     (H_TOTAL),
    .SYNC      (H_SYNC),
    .VIS_START (H_VIS_START),
    .VIS_END   (H_VIS_END)
  ) hAxis (
    .clk     (clk),
    .reset   (reset),
    .advance (pixEnReg),
    .count   (hCountInt),
    .sync    (hSyncInt),
    .visible (hVisible),
    .wrap    (hWrap)
  );

  vga_axis_counter #(
    .TOTAL     (V_TOTAL),
    .SYNC      (V_SYNC),
    .VIS_START (V_VIS_START),
    .VIS_END   (V_VIS_END)
  ) vAxis (
    .clk     (clk),
    .reset   (reset),
    .advance (hWrap),
    .count   (vCountInt),
    .sync    (vSyncInt),
    .visible (vVisible),
    .wrap    (vWrap)
  );

  // ---------------------------------------------------------------------
  // Ticks: registered on the edge where the counters wrap, so they are
  // high exactly while hCount (and vCount) read 0 for the first clock.
  // vWrap already implies hWrap, so frame_tick coincides with line_tick.
  // ---------------------------------------------------------------------
  logic lineTickReg;
  logic frameTickReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      lineTickReg  <= 1'b0;
      frameTickReg <= 1'b0;
    end else begin
      lineTickReg  <= hWrap;
      frameTickReg <= vWrap;
    end
  end

  // ---------------------------------------------------------------------
  // Raster position bundle.
  // ---------------------------------------------------------------------
  raster_pos_t rasterPos;

  assign rasterPos.hCount = hCountInt;
  assign rasterPos.vCount = vCountInt;
  assign rasterPos.bright = hVisible && vVisible;

`ifdef VGA_CELL_COORD_EN
  // ---------------------------------------------------------------------
  // Cell coordinates without division. Each axis keeps a sub-counter of
  // 0..CELL_PX-1 that runs only while the axis is visible and the next
  // step stays visible; any other step (leaving, or approaching the start)
  // clears both the sub-counter and the cell index, so the index is 0
  // when the axis enters its visible region and holds 0 outside it.
  // Index 0 is horizontal (stepped by pix_en), index 1 is vertical
  // (stepped by each line wrap).
  // ---------------------------------------------------------------------
  localparam logic [COUNT_W-1:0] CELL_LAST = COUNT_W'(CELL_PX - 1);
  localparam logic [COUNT_W-1:0] H_LEAVE   = COUNT_W'(H_VIS_END - 1);
  localparam logic [COUNT_W-1:0] V_LEAVE   = COUNT_W'(V_VIS_END - 1);

  logic              axisAdvance [2];
  logic              axisVisible [2];
  logic              axisLeaving [2];
  logic [CELL_W-1:0] cellOut     [2];

  assign axisAdvance[0] = pixEnReg;
  assign axisAdvance[1] = hWrap;
  assign axisVisible[0] = hVisible;
  assign axisVisible[1] = vVisible;
  assign axisLeaving[0] = (hCountInt == H_LEAVE);
  assign axisLeaving[1] = (vCountInt == V_LEAVE);

  for (genvar gi = 0; gi < 2; gi++) begin : gCellAxis
    logic [COUNT_W-1:0] subReg;
    logic [CELL_W-1:0]  cellReg;

    always_ff @(posedge clk) begin
      if (reset) begin
        subReg  <= '0;
        cellReg <= '0;
      end else if (axisAdvance[gi]) begin
        if (axisVisible[gi] && !axisLeaving[gi]) begin
          if (subReg == CELL_LAST) begin
            subReg  <= '0;
            cellReg <= cellReg + CELL_W'(1);
          end else begin
            subReg  <= subReg + COUNT_W'(1);
          end
        end else begin
          subReg  <= '0;
          cellReg <= '0;
        end
      end
    end

    assign cellOut[gi] = cellReg;
  end

  assign cellX = cellOut[0];
  assign cellY = cellOut[1];
`else
  assign cellX = '0;
  assign cellY = '0;
`endif

  // ---------------------------------------------------------------------
  // Outputs.
  // ---------------------------------------------------------------------
  assign pix_en     = pixEnReg;
  assign hCount     = rasterPos.hCount;
  assign vCount     = rasterPos.vCount;
  assign bright     = rasterPos.bright;
  assign hSync      = hSyncInt;
  assign vSync      = vSyncInt;
  assign line_tick  = lineTickReg;
  assign frame_tick = frameTickReg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen -- self-checking bench for vga_timing_gen.
//
// Uses a scaled-down raster so several whole frames fit in a short run.
// The reference model derives every output from the number of clock edges
// since reset release using plain arithmetic (pixel index, div/mod), and
// every output is compared on every clock, away from the active edge.
module tb_vga_timing_gen;

  localparam int D    = 3;   // clocks per pixel
  localparam int HT   = 40;
  localparam int HS   = 5;
  localparam int HVS  = 8;
  localparam int HVE  = 38;
  localparam int VT   = 20;
  localparam int VS   = 2;
  localparam int VVS  = 4;
  localparam int VVE  = 18;
  localparam int CELL = 3;
  localparam int FRAME_CLKS = HT * VT * D;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_en;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       hSync;
  logic       vSync;
  logic       bright;
  logic       line_tick;
  logic       frame_tick;
  logic [6:0] cellX;
  logic [6:0] cellY;

  int compared = 0;
  int mismatched = 0;
  int n = 0;          // clock edges since reset was released (0 = in reset)

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV     (D),
    .H_TOTAL     (HT),
    .H_SYNC      (HS),
    .H_VIS_START (HVS),
    .H_VIS_END   (HVE),
    .V_TOTAL     (VT),
    .V_SYNC      (VS),
    .V_VIS_START (VVS),
    .V_VIS_END   (VVE),
    .CELL_PX     (CELL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .hCount     (hCount),
    .vCount     (vCount),
    .hSync      (hSync),
    .vSync      (vSync),
    .bright     (bright),
    .line_tick  (line_tick),
    .frame_tick (frame_tick),
    .cellX      (cellX),
    .cellY      (cellY)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s at t=%0t n=%0d: observed %0d, expected %0d", tag, $time, n, obs, exp);
    end
  endtask

  // Reference: pixel index p = number of pix_en strobes already consumed.
  // pix_en is high after edges D, 2D, 3D...; the counters step on the edge
  // following each strobe.
  task automatic checkAll();
    int p, h, v, ex, ey;
    bit adv, pe, br;
    p   = (n >= 1) ? (n - 1) / D : 0;
    h   = p % HT;
    v   = (p / HT) % VT;
    pe  = (n >= D) && (n % D == 0);
    adv = (n >= D + 1) && ((n - 1) % D == 0);
    br  = (h >= HVS) && (h < HVE) && (v >= VVS) && (v < VVE);
    ex  = 0;
    ey  = 0;
`ifdef VGA_CELL_COORD_EN
    if (h >= HVS && h < HVE) ex = (h - HVS) / CELL;
    if (v >= VVS && v < VVE) ey = (v - VVS) / CELL;
`endif
    chk("pix_en", int'(pix_en), int'(pe));
    chk("hCount", int'(hCount), h);
    chk("vCount", int'(vCount), v);
    chk("hSync", int'(hSync), int'(n > 0 && h >= HS));
    chk("vSync", int'(vSync), int'(n > 0 && v >= VS));
    chk("bright", int'(bright), int'(br));
    chk("line_tick", int'(line_tick), int'(adv && h == 0));
    chk("frame_tick", int'(frame_tick), int'(adv && h == 0 && v == 0));
    chk("cellX", int'(cellX), ex);
    chk("cellY", int'(cellY), ey);
  endtask

  // One clock: drive reset for the coming edge, then check just after it.
  task automatic stepClk(input logic rst);
    reset = rst;
    @(posedge clk);
    #1;
    if (rst) n = 0;
    else     n++;
    checkAll();
  endtask

  task automatic runClks(input int cnt);
    for (int i = 0; i < cnt; i++) stepClk(1'b0);
  endtask

  initial begin
    int hits;
    bit reached;

    // Step 1: reset state.
    for (int i = 0; i < 4; i++) stepClk(1'b1);
    $display("reset held: all outputs at reset values checked");

    // Step 2: release and run three whole frames plus a little.
    runClks(3 * FRAME_CLKS + 50);
    $display("three frames checked, now at (%0d,%0d)", hCount, vCount);

    // Step 3: reach a mid-frame pixel, reset for one clock, run a frame.
    reached = 1'b0;
    for (int i = 0; i < FRAME_CLKS + 10 && !reached; i++) begin
      stepClk(1'b0);
      if (hCount == 10'd20 && vCount == 10'd10) reached = 1'b1;
    end
    chk("reach_mid_frame", int'(reached), 1);
    stepClk(1'b1);
    $display("mid-frame reset applied: hCount=%0d vCount=%0d", hCount, vCount);
    hits = 0;
    for (int i = 0; i < FRAME_CLKS + 20; i++) begin
      stepClk(1'b0);
      if (frame_tick) hits++;
    end
    chk("frame_ticks_after_reset", hits, 1);
    $display("frame after reset checked, frame_tick count %0d", hits);

    // Step 4: random run lengths with random short resets.
    for (int k = 0; k < 8; k++) begin
      int len, rlen;
      len  = int'($urandom_range(50, 3000));
      rlen = int'($urandom_range(1, 3));
      runClks(len);
      for (int j = 0; j < rlen; j++) stepClk(1'b1);
      $display("random segment %0d: ran %0d clks, reset %0d clks", k, len, rlen);
    end
    runClks(FRAME_CLKS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock.
- Produces the hCount/vCount/bright raster interface consumed by the game/pixel logic, plus hSync/vSync to the connector and per-line and per-frame ticks that pace game-state updates.
- Sync-first counter convention: visible window is hCount 144..783 and vCount 35..514.
- Optional registered grid-cell coordinates, so pixel logic can index snake cells without dividers.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); must be >= 1.
- H_TOTAL, 800, pixel clocks per line.
- H_SYNC, 96, hSync low width, counts 0..H_SYNC-1.
- H_VIS_START, 144, first visible hCount.
- H_VIS_END, 784, first non-visible hCount after the visible region.
- V_TOTAL, 525, lines per frame.
- V_SYNC, 2, vSync low width, lines 0..V_SYNC-1.
- V_VIS_START, 35, first visible vCount.
- V_VIS_END, 515, first non-visible vCount after the visible region.
- CELL_PX, 10, pixels per grid cell side (64x48 grid).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- pix_en  out  1  one-clk strobe every CLK_DIV clocks; counters advance on it.
- hCount  out  10  horizontal count, 0..H_TOTAL-1.
- vCount  out  10  vertical count, 0..V_TOTAL-1.
- hSync  out  1  active-low horizontal sync.
- vSync  out  1  active-low vertical sync.
- bright  out  1  high inside the visible window.
- line_tick  out  1  one-clk pulse when hCount wraps to 0.
- frame_tick  out  1  one-clk pulse when (hCount,vCount) wraps to (0,0).
- cellX  out  7  visible column / CELL_PX, 0..63.
- cellY  out  7  visible row / CELL_PX, 0..47.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: prescaler 0, pix_en 0, hCount 0, vCount 0, hSync 0, vSync 0, bright 0, line_tick 0, frame_tick 0, cellX 0, cellY 0.
- Prescaler: counts 0..CLK_DIV-1. pix_en is high in the clk where the prescaler equals CLK_DIV-1. First pix_en occurs CLK_DIV clks after reset deasserts. CLK_DIV=1 gives pix_en constantly high.
- Counter advance, on pix_en only:
  - hCount increments; at H_TOTAL-1 it wraps to 0 and vCount increments.
  - vCount wraps to 0 from V_TOTAL-1 when hCount also wraps.
  - Counters hold between pix_en strobes.
- Registered decodes: hSync, vSync, bright, cellX and cellY are registers updated in the same edge as the counters. They always describe the hCount/vCount values currently on the outputs, so there is zero skew between the counters and their decodes.
- Decode equations:
  - hSync = (hCount >= H_SYNC).
  - vSync = (vCount >= V_SYNC).
  - bright = H_VIS_START <= hCount < H_VIS_END and V_VIS_START <= vCount < V_VIS_END.
- Ticks:
  - line_tick is high for exactly the one clk in which hCount becomes 0.
  - frame_tick is high for exactly the one clk in which the pair becomes (0,0).
  - Both are low in all other clks, including non-pix_en clks.
  - In the frame-wrap clk, line_tick and frame_tick are asserted together.
- Cell counters (no division):
  - Horizontal sub-counter counts 0..CELL_PX-1. It is reset to 0, with cellX=0, when hCount becomes H_VIS_START.
  - At CELL_PX-1 the sub-counter wraps and cellX increments.
  - Outside the visible columns, cellX holds 0.
  - cellY works the same way on line boundaries (when hCount wraps) using vCount and V_VIS_START, and holds 0 outside the visible rows.
  - cellX/cellY are don't-care when bright=0, but they must still follow the hold-0 rule.
- Reset mid-frame: takes effect on the next clk edge regardless of pix_en. All state returns to the reset values and the raster restarts at (0,0). No frame_tick is issued for the reset itself.
- Width rules: all compares are unsigned 10-bit. Parameters must satisfy H_VIS_END <= H_TOTAL and V_VIS_END <= V_TOTAL; simulation asserts this.

Optional Feature:
- VGA_CELL_COORD_EN defined: the cell sub-counters and cellX/cellY logic are built as described above.
- Undefined: the cell logic is not built, and cellX/cellY are tied to 0. The ports always exist, so the top level is unchanged.

Decomposition:
- Shared package vga_pkg holds the 640x480 timing constants (totals, sync widths, visible start/end), CELL_PX, the grid dimensions 64/48, and a raster-position struct (hCount, vCount, bright).
- Natural sub-module: vga_axis_counter, instantiated once per axis (horizontal and vertical).
  - Parameterised by total, sync width, visible start and visible end.
  - Inputs: advance enable. Outputs: count, sync, visible, wrap.

Test Plan:
- Reset release, CLK_DIV=4 -> first pix_en at clk 4; hCount=1 after the first pix_en; all outputs 0 before it.
- One full line -> hSync low for exactly 96 pixels (hCount 0..95); bright low while vCount=0; line_tick once per 800 pixels = 3200 clks.
- Full frame -> frame_tick period exactly 420000 pixels = 1,680,000 clks; vSync low for lines 0..1; bright first high at (144,35) and last high at (783,514).
- Visible pixel (154,45), VGA_CELL_COORD_EN defined -> cellX=1, cellY=1; (783,514) -> cellX=63, cellY=47; (143,35) -> cellX=0.
- Assert reset at (400,300) for 1 clk -> next clk all outputs at reset values; raster restarts; no spurious frame_tick.
- Build without VGA_CELL_COORD_EN -> cellX/cellY constant 0 for a full frame; sync/bright timing identical to the enabled build.
